// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared registered ALU
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [5:0]        req_funct3,
    input  logic [13:0]       req_funct7,
    input  logic [9:0]        req_index,
    input  logic [2*XLEN-1:0] req_value1,
    input  logic [2*XLEN-1:0] req_value2,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [2:0]        alu_funct3,
    output logic [6:0]        alu_funct7,
    output logic [4:0]        alu_index,
    output logic [XLEN-1:0]   alu_value1,
    output logic [XLEN-1:0]   alu_value2,
    input  logic [XLEN-1:0]   alu_out,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic            last_grant;
    logic            cur_grant;
    logic            sel;
    logic            accept;
    logic            resp_fire;
    logic [2:0]      op_funct3;
    logic [6:0]      op_funct7;
    logic [4:0]      op_index;
    logic [XLEN-1:0] op_value1;
    logic [XLEN-1:0] op_value2;

    // Pick the requester to serve: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_grant;
            default: sel = 1'b0;
        endcase
    end

    assign accept    = !rst && (state == IDLE) && (req_valid != 2'b00);
    assign resp_fire = !rst && (state == DONE) && resp_ready[cur_grant];

    // Handshake outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_data  = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
        if (!rst && (state == DONE)) begin
            resp_valid[cur_grant] = 1'b1;
            resp_data             = alu_out;
        end
    end

    assign busy = !rst && (state != IDLE);

    // FSM, grant bookkeeping and operand capture; operands stay frozen until the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_grant  <= 1'b0;
            op_funct3  <= '0;
            op_funct7  <= '0;
            op_index   <= '0;
            op_value1  <= '0;
            op_value2  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_grant <= sel;
                        op_funct3 <= sel ? req_funct3[5:3] : req_funct3[2:0];
                        op_funct7 <= sel ? req_funct7[13:7] : req_funct7[6:0];
                        op_index  <= sel ? req_index[9:5] : req_index[4:0];
                        op_value1 <= sel ? req_value1[2*XLEN-1:XLEN] : req_value1[XLEN-1:0];
                        op_value2 <= sel ? req_value2[2*XLEN-1:XLEN] : req_value2[XLEN-1:0];
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    state <= DONE;
                end
                DONE: begin
                    if (resp_fire) begin
                        last_grant <= cur_grant;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign alu_funct3 = op_funct3;
    assign alu_funct7 = op_funct7;
    assign alu_index  = op_index;
    assign alu_value1 = op_value1;
    assign alu_value2 = op_value2;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int XLEN = 32;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [5:0]        req_funct3;
    logic [13:0]       req_funct7;
    logic [9:0]        req_index;
    logic [2*XLEN-1:0] req_value1;
    logic [2*XLEN-1:0] req_value2;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [2:0]        alu_funct3;
    logic [6:0]        alu_funct7;
    logic [4:0]        alu_index;
    logic [XLEN-1:0]   alu_value1;
    logic [XLEN-1:0]   alu_value2;
    logic [XLEN-1:0]   alu_out;
    logic              busy;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int r1_seen = 0;
    logic watch = 1'b0;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_index(req_index),
        .req_value1(req_value1), .req_value2(req_value2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_index(alu_index),
        .alu_value1(alu_value1), .alu_value2(alu_value2),
        .alu_out(alu_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU stand-in: result appears one clock after operands are presented.
    function automatic logic [XLEN-1:0] alu_calc(input logic [2:0] f3, input logic [6:0] f7,
                                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'b000:  alu_calc = f7[5] ? a - b : a + b;
            3'b100:  alu_calc = a ^ b;
            3'b110:  alu_calc = a | b;
            3'b111:  alu_calc = a & b;
            default: alu_calc = '0;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_calc(alu_funct3, alu_funct7, alu_value1, alu_value2);

    // Protocol watchers over the whole run.
    always @(negedge clk) begin
        if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) viol++;
        if (watch && (req_ready[1] || resp_valid[1])) r1_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            req_funct3[2:0] = f3;  req_funct7[6:0] = f7;  req_index[4:0] = idx;
            req_value1[31:0] = a;  req_value2[31:0] = b;
        end else begin
            req_funct3[5:3] = f3;  req_funct7[13:7] = f7; req_index[9:5] = idx;
            req_value1[63:32] = a; req_value2[63:32] = b;
        end
    endtask

    int grant_id[6];
    int grant_cyc[6];
    int ngrant;
    int nresp;

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        req_funct3 = '0; req_funct7 = '0; req_index = '0; req_value1 = '0; req_value2 = '0;
        set_req(0, 3'b000, 7'h00, 5'd3, 32'h11, 32'h22);
        set_req(1, 3'b100, 7'h00, 5'd4, 32'h33, 32'h44);

        // Reset with requests pending: everything quiet.
        next_cycle();
        next_cycle();
        mid();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_funct3", alu_funct3, 0);
        check("rst_alu_funct7", alu_funct7, 0);
        check("rst_alu_index", alu_index, 0);
        check("rst_alu_value1", alu_value1, 0);
        check("rst_alu_value2", alu_value2, 0);
        next_cycle();
        rst = 1'b0;
        req_valid = 2'b00;
        mid();
        check("post_rst_busy", busy, 0);

        // Single op: 5 + 7.
        next_cycle();
        set_req(0, 3'b000, 7'h00, 5'd9, 32'd5, 32'd7);
        req_valid = 2'b01;
        mid();
        check("t1_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        mid();
        check("t1_exec_busy", busy, 1);
        check("t1_exec_ready", req_ready, 2'b00);
        check("t1_exec_rv", resp_valid, 2'b00);
        check("t1_alu_index", alu_index, 9);
        check("t1_alu_value1", alu_value1, 5);
        check("t1_alu_value2", alu_value2, 7);
        next_cycle();
        mid();
        check("t1_rv", resp_valid, 2'b01);
        check("t1_data", resp_data, 12);
        next_cycle();
        mid();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_rv", resp_valid, 2'b00);
        check("t1_idle_data", resp_data, 0);

        // Tie right after reset: r0 first.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_req(0, 3'b100, 7'h00, 5'd1, 32'hF0, 32'h0F);
        set_req(1, 3'b000, 7'h00, 5'd1, 32'd1, 32'd2);
        req_valid = 2'b11;
        mid();
        check("t2_ready0", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b10;
        mid();
        check("t2_exec_ready", req_ready, 2'b00);
        next_cycle();
        mid();
        check("t2_rv0", resp_valid, 2'b01);
        check("t2_data0", resp_data, 32'hFF);
        check("t2_done_ready", req_ready, 2'b00);
        next_cycle();
        mid();
        check("t2_ready1", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        mid();
        check("t2_rv1", resp_valid, 2'b10);
        check("t2_data1", resp_data, 3);

        // Fairness: both valid for 18 cycles.
        next_cycle();
        set_req(0, 3'b000, 7'h00, 5'd2, 32'd10, 32'd20);
        set_req(1, 3'b000, 7'h20, 5'd2, 32'd100, 32'd1);
        req_valid = 2'b11;
        ngrant = 0;
        nresp = 0;
        for (int c = 0; c < 18; c++) begin
            mid();
            if (req_ready != 2'b00 && ngrant < 6) begin
                grant_id[ngrant] = req_ready[1] ? 1 : 0;
                grant_cyc[ngrant] = c;
                ngrant++;
            end
            if (resp_valid == 2'b01) begin
                check("t3_data_r0", resp_data, 30);
                nresp++;
            end else if (resp_valid == 2'b10) begin
                check("t3_data_r1", resp_data, 99);
                nresp++;
            end
            next_cycle();
        end
        req_valid = 2'b00;
        check("t3_ngrant", ngrant, 6);
        check("t3_nresp", nresp, 6);
        for (int k = 0; k < ngrant; k++) begin
            check($sformatf("t3_grant%0d", k), grant_id[k], k % 2);
            if (k > 0) check($sformatf("t3_gap%0d", k), grant_cyc[k] - grant_cyc[k-1], 3);
        end

        // Backpressure in DONE with r1 waiting.
        mid();
        check("t4_idle_busy", busy, 0);
        next_cycle();
        set_req(0, 3'b000, 7'h00, 5'd0, 32'd3, 32'd4);
        req_valid = 2'b01;
        resp_ready = 2'b00;
        mid();
        check("t4_ready0", req_ready, 2'b01);
        next_cycle();
        set_req(1, 3'b111, 7'h00, 5'd0, 32'hFF, 32'h0F);
        req_valid = 2'b10;
        next_cycle();
        for (int s = 0; s < 5; s++) begin
            mid();
            check("t4_stall_rv", resp_valid, 2'b01);
            check("t4_stall_data", resp_data, 7);
            check("t4_stall_busy", busy, 1);
            check("t4_stall_ready", req_ready, 2'b00);
            next_cycle();
        end
        resp_ready = 2'b01;
        mid();
        check("t4_rv", resp_valid, 2'b01);
        next_cycle();
        resp_ready = 2'b11;
        mid();
        check("t4_ready1", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        mid();
        check("t4_rv1", resp_valid, 2'b10);
        check("t4_data1", resp_data, 32'h0F);
        next_cycle();
        mid();
        check("t4_end_busy", busy, 0);

        // Reset during EXEC drops the op.
        next_cycle();
        set_req(0, 3'b100, 7'h00, 5'd0, 32'd1, 32'd3);
        req_valid = 2'b01;
        mid();
        check("t5_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b00;
        mid();
        check("t5_exec_busy", busy, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mid();
        check("t5_busy", busy, 0);
        check("t5_rv", resp_valid, 2'b00);
        check("t5_alu_value1", alu_value1, 0);
        next_cycle();
        mid();
        check("t5_rv_later", resp_valid, 2'b00);
        next_cycle();
        set_req(1, 3'b110, 7'h00, 5'd0, 32'd5, 32'd6);
        req_valid = 2'b10;
        mid();
        check("t5_new_ready", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        mid();
        check("t5_new_rv", resp_valid, 2'b10);
        check("t5_new_data", resp_data, 7);

        // r1 appears for one cycle while busy, then withdraws.
        next_cycle();
        set_req(0, 3'b000, 7'h00, 5'd0, 32'd2, 32'd2);
        req_valid = 2'b01;
        mid();
        check("t6_ready", req_ready, 2'b01);
        watch = 1'b1;
        next_cycle();
        set_req(1, 3'b000, 7'h00, 5'd0, 32'd9, 32'd9);
        req_valid = 2'b10;
        next_cycle();
        req_valid = 2'b00;
        mid();
        check("t6_rv", resp_valid, 2'b01);
        check("t6_data", resp_data, 4);
        for (int s = 0; s < 4; s++) begin
            next_cycle();
        end
        mid();
        watch = 1'b0;
        check("t6_r1_never", r1_seen, 0);
        check("t6_busy", busy, 0);

        check("ready_protocol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
